// File: rtl/usart_frame_sched.sv
// usart_frame_sched: round-robin frame scheduler in front of a byte-wide USART
// transmit engine. Each granted request sends HDR, channel id, then the 32-bit
// payload MSB first. Defining USART_FRAME_CHKSUM_EN appends an XOR checksum byte
// covering the channel id and the payload bytes.
module usart_frame_sched #(
   parameter int         NREQ      = 2,
   parameter logic [7:0] HDR       = 8'hA5,
   parameter int         TXEN_HOLD = 4,
   parameter int         BUSY_TO   = 16
) (
   input  logic              clkb,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [32*NREQ-1:0] payload,
   output logic [NREQ-1:0]   ack,
   output logic [7:0]        tx_data,
   output logic              tx_en,
   input  logic              tx_busy,
   output logic              sched_busy,
   output logic [2:0]        cur_ch,
   output logic              err_timeout
);

`ifdef USART_FRAME_CHKSUM_EN
   localparam int FLEN = 7;
`else
   localparam int FLEN = 6;
`endif
   localparam int HW = $clog2(TXEN_HOLD + 1);
   localparam int TW = $clog2(BUSY_TO + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_LOAD, S_PULSE, S_WAIT_BUSY, S_WAIT_DONE, S_DONE
   } state_t;

   state_t        state, state_nx;
   logic [2:0]    rr_ptr;
   logic [2:0]    bidx;
   logic [2:0]    win;
   logic          found;
   logic [31:0]   pay_sel;
   logic [31:0]   snap;
   logic [HW-1:0] hcnt;
   logic [TW-1:0] tcnt;
   logic          busy_seen;
   logic          grant, abort, next_byte, finish;

   // Byte of the frame at position idx; the checksum only exists in the
   // checksum build, so index 6 falls to the default otherwise.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                             input logic [2:0] ch,
                                             input logic [31:0] p);
      logic [7:0] chb;
      chb = {5'b0, ch};
      case (idx)
         3'd0:    frame_byte = HDR;
         3'd1:    frame_byte = chb;
         3'd2:    frame_byte = p[31:24];
         3'd3:    frame_byte = p[23:16];
         3'd4:    frame_byte = p[15:8];
         3'd5:    frame_byte = p[7:0];
`ifdef USART_FRAME_CHKSUM_EN
         3'd6:    frame_byte = chb ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
`endif
         default: frame_byte = 8'h00;
      endcase
   endfunction

   // Round-robin pick: first set req bit searching from rr_ptr+1 upward, wrapping
   always_comb begin
      win   = rr_ptr;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == (int'(rr_ptr) + k) % NREQ)) begin
               win   = 3'(i);
               found = 1'b1;
            end
         end
      end
   end

   // Payload slice belonging to the arbitration winner
   always_comb begin
      pay_sel = payload[31:0];
      for (int i = 0; i < NREQ; i++) begin
         if (win == 3'(i)) pay_sel = payload[32*i +: 32];
      end
   end

   // Next-state and single-cycle control strobes
   always_comb begin
      state_nx  = state;
      grant     = 1'b0;
      abort     = 1'b0;
      next_byte = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: if (|req) state_nx = S_ARB;
         S_ARB: begin
            // A request withdrawn between IDLE and ARB simply yields no grant.
            if (found) begin
               grant    = 1'b1;
               state_nx = S_LOAD;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_LOAD: state_nx = S_PULSE;
         S_PULSE: if (hcnt == HW'(TXEN_HOLD - 1)) state_nx = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            // busy_seen covers an engine that rose and fell again during the
            // pulse, so a short byte cannot be mistaken for a dead engine.
            if (tx_busy || busy_seen) begin
               state_nx = S_WAIT_DONE;
            end else if (tcnt >= TW'(BUSY_TO - 1)) begin
               abort    = 1'b1;
               state_nx = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (bidx == 3'(FLEN - 1)) begin
                  finish   = 1'b1;
                  state_nx = S_DONE;
               end else begin
                  next_byte = 1'b1;
                  state_nx  = S_LOAD;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register, grant bookkeeping and frame byte sequencing
   always_ff @(posedge clkb) begin
      if (rst) begin
         state       <= S_IDLE;
         rr_ptr      <= 3'(NREQ - 1);
         cur_ch      <= 3'd0;
         snap        <= 32'h0;
         bidx        <= 3'd0;
         tx_data     <= 8'h00;
         sched_busy  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state <= state_nx;
         if (grant) begin
            cur_ch     <= win;
            rr_ptr     <= win;
            snap       <= pay_sel;
            sched_busy <= 1'b1;
            bidx       <= 3'd0;
            tx_data    <= HDR;
         end
         if (next_byte) begin
            bidx    <= bidx + 3'd1;
            tx_data <= frame_byte(bidx + 3'd1, cur_ch, snap);
         end
         if (abort) begin
            err_timeout <= 1'b1;
            sched_busy  <= 1'b0;
         end
         if (finish) sched_busy <= 1'b0;
      end
   end

   // Pulse-width and busy-timeout counters; both restart in LOAD so the
   // timeout counts from the first cycle tx_en is high.
   always_ff @(posedge clkb) begin
      if (rst) begin
         hcnt      <= '0;
         tcnt      <= '0;
         busy_seen <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               hcnt      <= '0;
               tcnt      <= '0;
               busy_seen <= 1'b0;
            end
            S_PULSE: begin
               hcnt      <= hcnt + 1'b1;
               tcnt      <= tcnt + 1'b1;
               busy_seen <= busy_seen | tx_busy;
            end
            S_WAIT_BUSY: tcnt <= tcnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign tx_en = (state == S_PULSE);

   // One-cycle acknowledge to the served channel in DONE
   always_comb begin
      ack = '0;
      for (int i = 0; i < NREQ; i++) begin
         ack[i] = (state == S_DONE) && (cur_ch == 3'(i));
      end
   end

endmodule

// File: tb/tb_usart_frame_sched.sv
// Bench for usart_frame_sched: engine model, frame-level scoreboard, directed
// scenarios followed by a randomized request phase.
module tb_usart_frame_sched;
   localparam int NREQ      = 2;
   localparam int TXEN_HOLD = 4;
   localparam int BUSY_TO   = 16;
`ifdef USART_FRAME_CHKSUM_EN
   localparam int FLEN = 7;
`else
   localparam int FLEN = 6;
`endif

   logic                 clkb = 1'b0;
   logic                 rst  = 1'b1;
   logic [NREQ-1:0]      req  = '0;
   logic [32*NREQ-1:0]   payload = '0;
   logic [NREQ-1:0]      ack;
   logic [7:0]           tx_data;
   logic                 tx_en;
   logic                 tx_busy = 1'b0;
   logic                 sched_busy;
   logic [2:0]           cur_ch;
   logic                 err_timeout;

   always #5 clkb = ~clkb;

   usart_frame_sched #(.NREQ(NREQ), .HDR(8'hA5), .TXEN_HOLD(TXEN_HOLD), .BUSY_TO(BUSY_TO)) dut (
      .clkb(clkb), .rst(rst), .req(req), .payload(payload), .ack(ack),
      .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy), .sched_busy(sched_busy),
      .cur_ch(cur_ch), .err_timeout(err_timeout)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Round-robin rule: first requester after 'last', wrapping
   function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   // Inputs as the DUT saw them at the latest edge
   logic [NREQ-1:0]    req_s;
   logic [32*NREQ-1:0] pay_s;
   always @(posedge clkb) begin
      req_s <= req;
      pay_s <= payload;
   end

   // Model / monitor state
   int         m_rr = NREQ - 1;
   int         m_ch, m_idx, m_hold, t_since, c_pick, n_done;
   bit         m_active, m_err, prev_sb, prev_en;
   logic [7:0] m_frame [7];
   logic [7:0] m_cap;
   logic [31:0] pw;
   logic [7:0] last_frame [NREQ][7];
   int         grants[$];
   bit         eng_on = 1'b1;
   int         eng_dly, eng_cnt;

   // Scoreboard and engine model, evaluated away from the active edge
   always @(negedge clkb) begin
      if (rst) begin
         m_active = 1'b0; m_rr = NREQ - 1; m_idx = 0; m_err = 1'b0;
         eng_dly = 0; eng_cnt = 0; tx_busy = 1'b0; prev_sb = 1'b0; prev_en = 1'b0;
      end else begin
         if (t_since < 1000) t_since++;
         // new grant
         if (sched_busy && !prev_sb) begin
            c_pick = rr_pick(m_rr, req_s);
            chk("grant_overlap", m_active, 0);
            chk("grant_ch", cur_ch, c_pick);
            if (c_pick >= 0) begin
               m_rr = c_pick; m_ch = c_pick; grants.push_back(c_pick);
               pw = pay_s[32*c_pick +: 32];
               m_frame[0] = 8'hA5; m_frame[1] = 8'(c_pick);
               m_frame[2] = pw[31:24]; m_frame[3] = pw[23:16];
               m_frame[4] = pw[15:8];  m_frame[5] = pw[7:0];
               m_frame[6] = m_frame[1] ^ m_frame[2] ^ m_frame[3] ^ m_frame[4] ^ m_frame[5];
            end
            m_active = 1'b1; m_idx = 0;
         end
         // byte strobe
         if (tx_en && !prev_en) begin
            t_since = 0;
            chk("txen_in_frame", m_active && m_idx < FLEN, 1);
            if (m_active && m_idx < FLEN) begin
               chk("tx_byte", tx_data, m_frame[m_idx]);
               last_frame[m_ch][m_idx] = tx_data;
            end
            m_cap = tx_data; m_idx++; m_hold = 1;
         end else begin
            if (tx_en) m_hold++;
            if (!tx_en && prev_en) chk("txen_width", m_hold, TXEN_HOLD);
            if (m_active && m_idx > 0 && (tx_en || tx_busy)) chk("tx_data_hold", tx_data, m_cap);
         end
         if (m_active) chk("cur_ch_hold", cur_ch, m_ch);
         // end of frame: ack or abort
         if (!sched_busy && prev_sb) begin
            if (ack != 0) begin
               chk("ack_vec", ack, 64'(1) << m_ch);
               chk("ack_len", m_idx, FLEN);
               n_done++;
            end else begin
               chk("abort_expected", eng_on, 0);
               chk("timeout_delay", t_since, BUSY_TO);
               m_err = 1'b1;
            end
            m_active = 1'b0;
         end else if (ack != 0) begin
            chk("ack_stray", ack, 0);
         end
         if (!m_active) chk("idle_txen", tx_en, 0);
         chk("err_timeout", err_timeout, m_err);
         // engine: busy rises a few cycles after tx_en rises, holds, then falls
         if (eng_on) begin
            if (tx_en && !prev_en) eng_dly = $urandom_range(2, 4);
            else if (eng_dly > 0) begin
               eng_dly--;
               if (eng_dly == 0) begin tx_busy = 1'b1; eng_cnt = $urandom_range(3, 8); end
            end else if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) tx_busy = 1'b0;
            end
         end else begin
            tx_busy = 1'b0; eng_dly = 0; eng_cnt = 0;
         end
         prev_en = tx_en; prev_sb = sched_busy;
      end
   end

   task automatic wait_acks(input int n, input bit drop_each, input string name);
      int got = 0;
      for (int c = 0; c < 800 && got < n; c++) begin
         @(posedge clkb); #1;
         if (ack != 0) begin
            got++;
            if (got == n && !drop_each) req = '0;
            else if (drop_each) req = req & ~ack;
         end
      end
      chk(name, got, n);
   endtask

   logic [7:0] lit0 [7] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}; // 00^12^34^56^78
   logic [7:0] lit1 [7] = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23}; // 01^DE^AD^BE^EF
   bit hit;
   int done0;

   initial begin
      // reset values
      rst = 1'b1;
      repeat (3) @(posedge clkb);
      #1;
      chk("rst_ack", ack, 0);        chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_tx_en", tx_en, 0);    chk("rst_sched_busy", sched_busy, 0);
      chk("rst_cur_ch", cur_ch, 0);  chk("rst_err", err_timeout, 0);
      rst = 1'b0;

      // single request; payload overwritten two cycles after ARB
      payload[31:0] = 32'h12345678; req = 2'b01;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin @(posedge clkb); #1; hit = sched_busy; end
      chk("t1_grant_seen", hit, 1);
      @(posedge clkb); #1; payload[31:0] = 32'hFFFFFFFF;
      wait_acks(1, 1'b1, "t1_ack");
      for (int i = 0; i < FLEN; i++) chk("t1_literal", last_frame[0][i], lit0[i]);
      @(posedge clkb); #1;
      chk("t1_busy_after_ack", sched_busy, 0);

      // round-robin from reset with both requests held
      rst = 1'b1; @(posedge clkb); #1; rst = 1'b0;
      grants.delete();
      payload = {32'hDEADBEEF, 32'h12345678}; req = 2'b11;
      wait_acks(3, 1'b0, "rr_acks");
      chk("rr_count", grants.size(), 3);
      if (grants.size() == 3) begin
         chk("rr_g0", grants[0], 0); chk("rr_g1", grants[1], 1); chk("rr_g2", grants[2], 0);
      end
      for (int i = 0; i < FLEN; i++) chk("rr_ch1_literal", last_frame[1][i], lit1[i]);

      // reset while byte 3 is being sent
      payload[31:0] = 32'hCAFE0123; req = 2'b01;
      hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin @(posedge clkb); #1; hit = tx_en && (m_idx == 4); end
      chk("rstmid_reach_byte3", hit, 1);
      rst = 1'b1; @(posedge clkb); #1;
      chk("rstmid_tx_en", tx_en, 0); chk("rstmid_ack", ack, 0); chk("rstmid_sched_busy", sched_busy, 0);
      rst = 1'b0;
      wait_acks(1, 1'b1, "rstmid_restart_ack");
      chk("rstmid_restart_hdr", last_frame[0][0], 8'hA5);

      // engine dead: timeout
      eng_on = 1'b0; req = 2'b10;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin @(posedge clkb); #1; hit = err_timeout; end
      req = '0;
      chk("to_seen", hit, 1);
      repeat (3) @(posedge clkb);
      #1;
      chk("to_sched_busy", sched_busy, 0); chk("to_err_sticky", err_timeout, 1); chk("to_tx_en", tx_en, 0);
      eng_on = 1'b1;

      // randomized requests with payload churn and occasional early req drop
      done0 = n_done;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clkb); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 5) == 0) begin
               req[i] = 1'b1; payload[32*i +: 32] = $urandom;
            end else if (req[i] && sched_busy && cur_ch == 3'(i) && $urandom_range(0, 15) == 0) req[i] = 1'b0;
            if ($urandom_range(0, 3) == 0) payload[32*i +: 32] = $urandom;
         end
      end
      req = '0;
      hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin @(posedge clkb); #1; hit = !sched_busy && !tx_en; end
      chk("rand_drain", hit, 1);
      chk("rand_progress", (n_done - done0) > 10, 1);
      chk("rand_err_sticky", err_timeout, 1);
      rst = 1'b1; @(posedge clkb); #1; rst = 1'b0;
      chk("final_err_cleared", err_timeout, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
      $fatal(1);
   end

endmodule
